inference_sequencer: RTL and testbench

- Batch controller that runs N MNIST images, back to back, through the pixel streamer and the CNN.
- Per image: flushes the CNN, launches the streamer at the image's base address, waits for stream completion and the CNN classification, then emits one result record.
- Sits between the host/test control and the streamer + cnn_top pair; it owns image sequencing, timeout and result hand-off.

---
 rtl/cnn_pkg.sv | 31 +++
 rtl/inference_sequencer_if.sv | 34 +++
 rtl/seq_timer.sv | 26 ++
 rtl/inference_sequencer.sv | 155 +++++++++++++++
 tb/tb_inference_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the MNIST batch inference sequencer.
// Widths here also size the sequencer interface, so both stay consistent.
package cnn_pkg;

    localparam int MAX_IMAGES = 16;
    localparam int IMG_PIXELS = 784;
    localparam int CLASS_W    = 4;
    localparam int NUM_W      = $clog2(MAX_IMAGES + 1);
    localparam int IDX_W      = $clog2(MAX_IMAGES);
    localparam int BASE_W     = $clog2(MAX_IMAGES * IMG_PIXELS);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        LAUNCH,
        STREAM,
        EMIT,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [IDX_W-1:0]   idx;
        logic [CLASS_W-1:0] cls;
        logic               timeout;
    } seq_result_t;

    function automatic logic [NUM_W-1:0] clamp_images(input logic [NUM_W-1:0] n);
        return (n > NUM_W'(MAX_IMAGES)) ? NUM_W'(MAX_IMAGES) : n;
    endfunction

endpackage

// File: rtl/inference_sequencer_if.sv
// Control, streamer/CNN and result hand-off signals of the inference sequencer.
// slave is the sequencer side, master is the host/streamer/CNN side.
import cnn_pkg::*;

interface inference_sequencer_if;
    logic               start;
    logic [NUM_W-1:0]   num_images;
    logic               abort;
    logic               busy;
    logic               all_done;
    logic               img_start;
    logic [BASE_W-1:0]  img_base;
    logic               stream_done;
    logic               cnn_flush;
    logic               cnn_res_valid;
    logic [CLASS_W-1:0] cnn_res_class;
    logic               res_valid;
    logic               res_ready;
    logic [IDX_W-1:0]   res_idx;
    logic [CLASS_W-1:0] res_class;
    logic               res_timeout;

    modport master (
        output start, num_images, abort, stream_done, cnn_res_valid, cnn_res_class, res_ready,
        input  busy, all_done, img_start, img_base, cnn_flush, res_valid, res_idx, res_class,
               res_timeout
    );

    modport slave (
        input  start, num_images, abort, stream_done, cnn_res_valid, cnn_res_class, res_ready,
        output busy, all_done, img_start, img_base, cnn_flush, res_valid, res_idx, res_class,
               res_timeout
    );
endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter with zero flag; saturates at zero.
// Shared between the flush hold count and the per-image timeout.
module seq_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/inference_sequencer.sv
// Runs a batch of MNIST images through the streamer and CNN, one result record per image.
//
// state  | meaning
// IDLE   | waiting for start
// FLUSH  | cnn_flush held for FLUSH_CYCLES
// LAUNCH | img_start pulse, timeout loaded
// STREAM | collecting stream_done and CNN result, or timing out
// EMIT   | result record offered until res_ready
// DONE   | all_done pulse
module inference_sequencer
    import cnn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FLUSH_CYCLES   = 4
) (
    input logic                  clk,
    input logic                  rst,
    inference_sequencer_if.slave bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    // The timer reads zero on the last counted cycle, hence the offsets.
    localparam logic [TMR_W-1:0] FLUSH_LOAD = TMR_W'(FLUSH_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LOAD   = TMR_W'(TIMEOUT_CYCLES - 2);

    seq_state_t        state, state_nxt;
    seq_result_t       res_q;
    logic [NUM_W-1:0]  n_lat;
    logic [BASE_W-1:0] base_q;
    logic              got_stream, got_res;
    logic              zero_done;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]  tmr_val;
    logic              both_now, last_img, aborting;

    assign both_now = (got_stream || bus.stream_done) && (got_res || bus.cnn_res_valid);
    assign last_img = (NUM_W'(res_q.idx) == n_lat - NUM_W'(1));
    assign aborting = bus.abort && (state != IDLE);

    seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = FLUSH_LOAD;
        tmr_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && (bus.num_images != '0)) begin
                    state_nxt = FLUSH;
                    tmr_load  = 1'b1;
                end
            end
            FLUSH: begin
                tmr_dec = 1'b1;
                if (tmr_zero) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                state_nxt = STREAM;
                tmr_load  = 1'b1;
                tmr_val   = TMO_LOAD;
            end
            STREAM: begin
                tmr_dec = 1'b1;
                if (both_now || tmr_zero) state_nxt = EMIT;
            end
            EMIT: begin
                if (bus.res_ready) begin
                    if (last_img) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FLUSH;
                        tmr_load  = 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (aborting) begin
            state_nxt = IDLE;
            tmr_load  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q      <= '0;
            n_lat      <= '0;
            base_q     <= '0;
            got_stream <= 1'b0;
            got_res    <= 1'b0;
            zero_done  <= 1'b0;
        end else begin
            zero_done <= (state == IDLE) && bus.start && (bus.num_images == '0);
            if (!aborting) begin
                case (state)
                    IDLE: begin
                        if (bus.start && (bus.num_images != '0)) begin
                            n_lat  <= clamp_images(bus.num_images);
                            res_q  <= '0;
                            base_q <= '0;
                        end
                    end
                    LAUNCH: begin
                        got_stream    <= 1'b0;
                        got_res       <= 1'b0;
                        res_q.cls     <= '0;
                        res_q.timeout <= 1'b0;
                    end
                    STREAM: begin
                        if (bus.stream_done) got_stream <= 1'b1;
                        if (bus.cnn_res_valid && !got_res) begin
                            got_res   <= 1'b1;
                            res_q.cls <= bus.cnn_res_class;
                        end
                        // Expiry only counts when the capture did not complete this cycle.
                        if (!both_now && tmr_zero) begin
                            res_q.timeout <= 1'b1;
                            res_q.cls     <= '0;
                        end
                    end
                    EMIT: begin
                        if (bus.res_ready && !last_img) begin
                            res_q.idx <= res_q.idx + 1'b1;
                            base_q    <= base_q + BASE_W'(IMG_PIXELS);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.all_done    = (state == DONE) || zero_done;
    assign bus.img_start   = (state == LAUNCH);
    assign bus.cnn_flush   = (state == FLUSH);
    assign bus.res_valid   = (state == EMIT);
    assign bus.img_base    = base_q;
    assign bus.res_idx     = res_q.idx;
    assign bus.res_class   = res_q.cls;
    assign bus.res_timeout = res_q.timeout;
endmodule

// File: tb/tb_inference_sequencer.sv
// Self-checking bench for inference_sequencer: directed batches from the test plan
// plus random batches, each record checked against a per-image timing/result model.
module tb_inference_sequencer;
    import cnn_pkg::*;

    localparam int T = 4096;
    localparam int F = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   ad_total = 0;
    int   total = 0;
    int   bad = 0;

    int ds_a[MAX_IMAGES];
    int dr_a[MAX_IMAGES];
    int cls_a[MAX_IMAGES];
    int hold_a[MAX_IMAGES];

    inference_sequencer_if bus();

    inference_sequencer #(.TIMEOUT_CYCLES(T), .FLUSH_CYCLES(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) ad_total <= ad_total + int'(bus.all_done);

    task automatic check(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Image outcome from the event offsets relative to the img_start cycle.
    function automatic void model(input int ds, input int dr, input int cl,
                                  output int lat, output int ocl, output int oto);
        int m;
        m = (dr == 0) ? 32'h4000_0000 : ((ds > dr) ? ds : dr);
        if (m <= T - 1) begin
            lat = m + 1; ocl = cl; oto = 0;
        end else begin
            lat = T; ocl = 0; oto = 1;
        end
    endfunction

    task automatic set_img(input int k, input int ds, input int dr, input int cl, input int hold);
        ds_a[k] = ds; dr_a[k] = dr; cls_a[k] = cl; hold_a[k] = hold;
    endtask

    task automatic clear_inputs();
        bus.start = 1'b0; bus.abort = 1'b0; bus.stream_done = 1'b0;
        bus.cnn_res_valid = 1'b0; bus.cnn_res_class = '0; bus.res_ready = 1'b0;
    endtask

    task automatic run_batch(input int n_req, input int abort_img, input int abort_off);
        int n_exp, ref_c, ad0, L, E, rel, w, fl, lat, ocl, oto;
        n_exp = (n_req > MAX_IMAGES) ? MAX_IMAGES : n_req;
        @(negedge clk);
        ad0 = ad_total;
        bus.start = 1'b1;
        bus.num_images = NUM_W'(n_req);
        ref_c = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        if (n_exp == 0) begin
            check("zero_all_done", int'(bus.all_done), 1);
            check("zero_busy", int'(bus.busy), 0);
            @(negedge clk);
            check("zero_all_done_end", int'(bus.all_done), 0);
            check("zero_busy_end", int'(bus.busy), 0);
            repeat (2) @(negedge clk);
            check("zero_done_count", ad_total - ad0, 1);
            return;
        end
        for (int k = 0; k < n_exp; k++) begin
            fl = 0; w = 0;
            while (!bus.img_start) begin
                fl += int'(bus.cnn_flush);
                @(negedge clk);
                if (++w > 50) begin
                    check("launch_wait", 0, 1);
                    return;
                end
            end
            check("flush_len", fl, F);
            check("launch_lat", cyc - ref_c, F + 1);
            check("img_base", int'(bus.img_base), k * IMG_PIXELS);
            L = cyc;
            bus.res_ready = (hold_a[k] == 0);
            w = 0;
            while (!bus.res_valid) begin
                rel = cyc - L;
                bus.start = (rel == 2);
                bus.stream_done = (rel == ds_a[k]);
                bus.cnn_res_valid = (dr_a[k] != 0) && ((rel == dr_a[k]) || (rel == dr_a[k] + 1));
                bus.cnn_res_class = (rel == dr_a[k]) ? CLASS_W'(cls_a[k]) : CLASS_W'(cls_a[k] ^ 15);
                if ((k == abort_img) && (rel == abort_off)) begin
                    bus.abort = 1'b1;
                    @(negedge clk);
                    clear_inputs();
                    check("abort_busy", int'(bus.busy), 0);
                    check("abort_res_valid", int'(bus.res_valid), 0);
                    check("abort_img_start", int'(bus.img_start), 0);
                    check("abort_flush", int'(bus.cnn_flush), 0);
                    repeat (10) @(negedge clk);
                    check("abort_idle", int'(bus.busy), 0);
                    check("abort_no_done", ad_total - ad0, 0);
                    return;
                end
                @(negedge clk);
                if (++w > T + 20) begin
                    check("emit_wait", 0, 1);
                    return;
                end
            end
            bus.start = 1'b0; bus.stream_done = 1'b0; bus.cnn_res_valid = 1'b0;
            E = cyc;
            model(ds_a[k], dr_a[k], cls_a[k], lat, ocl, oto);
            check("emit_lat", E - L, lat);
            check("res_idx", int'(bus.res_idx), k);
            check("res_class", int'(bus.res_class), ocl);
            check("res_timeout", int'(bus.res_timeout), oto);
            bus.res_ready = (hold_a[k] == 0);
            for (int i = 1; i <= hold_a[k]; i++) begin
                @(negedge clk);
                check("hold_valid", int'(bus.res_valid), 1);
                check("hold_idx", int'(bus.res_idx), k);
                check("hold_class", int'(bus.res_class), ocl);
                check("hold_flush", int'(bus.cnn_flush), 0);
                bus.res_ready = (i == hold_a[k]);
            end
            ref_c = cyc;
            @(negedge clk);
            if (k == n_exp - 1) begin
                bus.res_ready = 1'b0;
                check("all_done", int'(bus.all_done), 1);
                check("done_busy", int'(bus.busy), 1);
                @(negedge clk);
                check("idle_busy", int'(bus.busy), 0);
                check("idle_all_done", int'(bus.all_done), 0);
            end
        end
        repeat (2) @(negedge clk);
        check("done_count", ad_total - ad0, 1);
    endtask

    task automatic random_batch(input int n);
        for (int k = 0; k < n; k++)
            set_img(k, $urandom_range(1, 40), $urandom_range(1, 60), $urandom_range(0, 15),
                    $urandom_range(0, 3));
        run_batch(n, -1, 0);
    endtask

    initial begin
        clear_inputs();
        bus.num_images = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_all_done", int'(bus.all_done), 0);
        check("rst_img_start", int'(bus.img_start), 0);
        check("rst_flush", int'(bus.cnn_flush), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_img_base", int'(bus.img_base), 0);
        check("rst_res_idx", int'(bus.res_idx), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        set_img(0, 784, 884, 7, 0);
        set_img(1, 784, 884, 2, 0);
        set_img(2, 784, 884, 9, 0);
        run_batch(3, -1, 0);

        set_img(0, 784, 50, 5, 0);
        run_batch(1, -1, 0);

        set_img(0, 10, 20, 3, 0);
        set_img(1, 784, 0, 8, 1);
        run_batch(2, -1, 0);

        set_img(0, 30, 40, 11, 20);
        set_img(1, 5, 6, 4, 0);
        run_batch(2, -1, 0);

        set_img(0, T - 1, 5, 13, 0);
        set_img(1, T, 5, 12, 0);
        set_img(2, T - 1, T - 1, 1, 2);
        run_batch(3, -1, 0);

        set_img(0, 20, 20, 6, 0);
        set_img(1, 784, 900, 6, 0);
        run_batch(2, 1, 100);
        set_img(0, 12, 15, 6, 0);
        run_batch(1, -1, 0);

        run_batch(0, -1, 0);
        random_batch(20);

        for (int r = 0; r < 6; r++) random_batch($urandom_range(1, 5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
